// File: rtl/wb_port_arbiter_if.sv
// Writeback arbitration bundle: per-requester result handshake plus the registered
// register-file write ports driven by the arbiter.
interface wb_port_arbiter_if #(
    parameter int NUM_REQ       = 4,
    parameter int NUM_GRANT     = 2,
    parameter int WORD_SIZE     = 64,
    parameter int NUM_PHYS_REGS = 128
);
    localparam int PREG_W = $clog2(NUM_PHYS_REGS);

    logic [NUM_REQ-1:0]                   req_valid;
    logic [NUM_REQ-1:0][PREG_W-1:0]       req_index;
    logic [NUM_REQ-1:0][WORD_SIZE-1:0]    req_data;
    logic [NUM_REQ-1:0]                   req_ready;
    logic [NUM_GRANT-1:0]                 wb_en;
    logic [NUM_GRANT-1:0][PREG_W-1:0]     wb_index;
    logic [NUM_GRANT-1:0][WORD_SIZE-1:0]  wb_data;
    logic [NUM_REQ-1:0]                   starved;

    modport master (
        output req_valid, req_index, req_data,
        input  req_ready, wb_en, wb_index, wb_data, starved
    );

    modport slave (
        input  req_valid, req_index, req_data,
        output req_ready, wb_en, wb_index, wb_data, starved
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Round-robin writeback arbiter with starvation override: accepts up to NUM_GRANT
// results per cycle (never two to the same register) and drives them registered.
module wb_port_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int NUM_GRANT     = 2,
    parameter int WORD_SIZE     = 64,
    parameter int NUM_PHYS_REGS = 128,
    parameter int STARVE_LIMIT  = 7
) (
    input  logic              clk,
    input  logic              rst,
    wb_port_arbiter_if.slave  bus
);
    localparam int PREG_W = $clog2(NUM_PHYS_REGS);
    localparam int REQ_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);
    localparam int SEL_W  = $clog2(NUM_GRANT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic [REQ_W-1:0]                    r_rr_ptr;
    logic [NUM_GRANT-1:0]                r_wb_en;
    logic [NUM_GRANT-1:0][PREG_W-1:0]    r_wb_index;
    logic [NUM_GRANT-1:0][WORD_SIZE-1:0] r_wb_data;

    logic [NUM_REQ-1:0]                  w_starved;
    logic [NUM_REQ-1:0]                  w_ready;
    logic [NUM_GRANT-1:0]                w_slot_used;
    logic [NUM_GRANT-1:0][REQ_W-1:0]     w_slot_req;
    logic [NUM_GRANT-1:0][PREG_W-1:0]    w_slot_index;
    logic [SEL_W-1:0]                    w_nsel;
    logic [REQ_W-1:0]                    w_last_req;
    logic [REQ_W:0]                      w_scan;
    logic [REQ_W-1:0]                    w_cand;
    logic                                w_clash;

    // Pass 0 admits only saturated requesters, pass 1 the rest; both scan from rr_ptr.
    always_comb begin
        w_ready      = '0;
        w_slot_used  = '0;
        w_slot_req   = '0;
        w_slot_index = '0;
        w_nsel       = '0;
        w_last_req   = '0;
        w_scan       = '0;
        w_cand       = '0;
        w_clash      = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                w_scan = {1'b0, r_rr_ptr} + (REQ_W+1)'(k);
                if (w_scan >= (REQ_W+1)'(NUM_REQ))
                    w_scan = w_scan - (REQ_W+1)'(NUM_REQ);
                w_cand = w_scan[REQ_W-1:0];
                if (bus.req_valid[w_cand] && (w_starved[w_cand] == (p == 0)) &&
                    (w_nsel < SEL_W'(NUM_GRANT))) begin
                    w_clash = 1'b0;
                    for (int s = 0; s < NUM_GRANT; s++)
                        if ((SEL_W'(s) < w_nsel) && (w_slot_index[s] == bus.req_index[w_cand]))
                            w_clash = 1'b1;
                    if (!w_clash) begin
                        for (int s = 0; s < NUM_GRANT; s++) begin
                            if (SEL_W'(s) == w_nsel) begin
                                w_slot_used[s]  = 1'b1;
                                w_slot_req[s]   = w_cand;
                                w_slot_index[s] = bus.req_index[w_cand];
                            end
                        end
                        w_ready[w_cand] = 1'b1;
                        w_last_req      = w_cand;
                        w_nsel          = w_nsel + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.req_ready = rst ? '0 : w_ready;
    assign bus.wb_en     = r_wb_en;
    assign bus.wb_index  = r_wb_index;
    assign bus.wb_data   = r_wb_data;
    assign bus.starved   = w_starved;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr   <= '0;
            r_wb_en    <= '0;
            r_wb_index <= '0;
            r_wb_data  <= '0;
        end else begin
            r_wb_en <= w_slot_used;
            for (int s = 0; s < NUM_GRANT; s++) begin
                if (w_slot_used[s]) begin
                    r_wb_index[s] <= w_slot_index[s];
                    r_wb_data[s]  <= bus.req_data[w_slot_req[s]];
                end
            end
            if (|w_slot_used)
                r_rr_ptr <= (w_last_req == REQ_W'(NUM_REQ - 1)) ? '0 : w_last_req + 1'b1;
        end
    end

    // Counts consecutive stalled cycles; a saturated counter wins pass 0 next cycle.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_starve
        logic [CNT_W-1:0] r_cnt;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r_cnt <= '0;
            else if (bus.req_valid[gi] && !w_ready[gi]) begin
                if (r_cnt != CNT_MAX)
                    r_cnt <= r_cnt + 1'b1;
            end else
                r_cnt <= '0;
        end
        assign w_starved[gi] = (r_cnt == CNT_MAX);
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a reference model predicts ready/starved each
// cycle and queues the writeback expected on the following cycle.
module tb_wb_port_arbiter;
    localparam int NR  = 4;
    localparam int NG  = 2;
    localparam int W   = 64;
    localparam int NPR = 128;
    localparam int SL  = 2;
    localparam int PW  = $clog2(NPR);

    typedef struct {
        logic [NG-1:0] en;
        logic [PW-1:0] idx  [NG];
        logic [W-1:0]  data [NG];
    } wb_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_port_arbiter_if #(.NUM_REQ(NR), .NUM_GRANT(NG), .WORD_SIZE(W), .NUM_PHYS_REGS(NPR)) bus ();

    wb_port_arbiter #(
        .NUM_REQ(NR), .NUM_GRANT(NG), .WORD_SIZE(W), .NUM_PHYS_REGS(NPR), .STARVE_LIMIT(SL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int            n_checks = 0;
    int            n_pass   = 0;
    int            m_rr;
    int            m_cnt [NR];
    logic [NR-1:0] m_rdy;
    wb_exp_t       sb [$];

    logic [NR-1:0] obs_ready, obs_starved;
    logic [NG-1:0] obs_wb_en;
    logic [PW-1:0] obs_idx0;
    logic [W-1:0]  obs_data0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_rr = 0;
        for (int i = 0; i < NR; i++) m_cnt[i] = 0;
        m_rdy = '0;
        sb.delete();
    endtask

    // One clock: sample at negedge, compare, predict, then return at posedge+1 for driving.
    task automatic cycle(input string tag);
        wb_exp_t       e, prev;
        int            order [$];
        int            chosen [$];
        bit            clash;
        logic [NR-1:0] exp_rdy, exp_st;
        @(negedge clk);
        obs_ready   = bus.req_ready;
        obs_starved = bus.starved;
        obs_wb_en   = bus.wb_en;
        obs_idx0    = bus.wb_index[0];
        obs_data0   = bus.wb_data[0];
        if (sb.size() > 0) begin
            prev = sb.pop_front();
            check_eq({tag, "/wb_en"}, 64'(bus.wb_en), 64'(prev.en));
            for (int s = 0; s < NG; s++) begin
                if (prev.en[s]) begin
                    check_eq({tag, "/wb_index"}, 64'(bus.wb_index[s]), 64'(prev.idx[s]));
                    check_eq({tag, "/wb_data"}, bus.wb_data[s], prev.data[s]);
                end
            end
        end else
            check_eq({tag, "/wb_en_idle"}, 64'(bus.wb_en), 64'(0));

        exp_st = '0;
        for (int i = 0; i < NR; i++) exp_st[i] = (m_cnt[i] == SL);
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < NR; k++) begin
                int i;
                i = (m_rr + k) % NR;
                if (bus.req_valid[i] && (exp_st[i] == (p == 0))) order.push_back(i);
            end
        foreach (order[j]) begin
            clash = 0;
            foreach (chosen[c]) if (bus.req_index[chosen[c]] == bus.req_index[order[j]]) clash = 1;
            if (!clash && chosen.size() < NG) chosen.push_back(order[j]);
        end
        exp_rdy = '0;
        e.en = '0;
        for (int s = 0; s < NG; s++) begin
            e.idx[s]  = '0;
            e.data[s] = '0;
        end
        foreach (chosen[s]) begin
            exp_rdy[chosen[s]] = 1'b1;
            e.en[s]   = 1'b1;
            e.idx[s]  = bus.req_index[chosen[s]];
            e.data[s] = bus.req_data[chosen[s]];
        end
        check_eq({tag, "/ready"}, 64'(bus.req_ready), 64'(exp_rdy));
        check_eq({tag, "/starved"}, 64'(bus.starved), 64'(exp_st));
        sb.push_back(e);

        if (chosen.size() > 0) m_rr = (chosen[chosen.size()-1] + 1) % NR;
        for (int i = 0; i < NR; i++) begin
            if (bus.req_valid[i] && !exp_rdy[i]) m_cnt[i] = (m_cnt[i] < SL) ? m_cnt[i] + 1 : SL;
            else m_cnt[i] = 0;
        end
        m_rdy = exp_rdy;
        $display("%s: valid=%b ready=%b starved=%b wb_en=%b", tag, bus.req_valid, obs_ready,
                 obs_starved, obs_wb_en);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic new_req(input int i);
        bus.req_valid[i] = ($urandom_range(0, 3) != 0);
        bus.req_index[i] = PW'($urandom_range(0, 5));
        bus.req_data[i]  = {$urandom, $urandom};
    endtask

    initial begin
        model_reset();
        bus.req_valid = '1;
        for (int i = 0; i < NR; i++) begin
            bus.req_index[i] = PW'(10 + i);
            bus.req_data[i]  = 64'h100 + 64'(i);
        end
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 64'(bus.req_ready), 64'(0));
        check_eq("rst_wb_en", 64'(bus.wb_en), 64'(0));
        check_eq("rst_starved", 64'(bus.starved), 64'(0));
        rst = 1'b0;

        cycle("rr0");  check_eq("rr0_grant", 64'(obs_ready), 64'(4'b0011));
        cycle("rr1");  check_eq("rr1_grant", 64'(obs_ready), 64'(4'b1100));
        cycle("rr2");  check_eq("rr2_grant", 64'(obs_ready), 64'(4'b0011));
        check_eq("rr2_wb_en", 64'(obs_wb_en), 64'(2'b11));
        cycle("rr3");  check_eq("rr3_wb_en", 64'(obs_wb_en), 64'(2'b11));

        apply_reset();
        bus.req_valid = 4'b0111;
        bus.req_index[0] = PW'(5);
        bus.req_index[1] = PW'(5);
        bus.req_index[2] = PW'(9);
        bus.req_index[3] = PW'(0);
        cycle("conf0"); check_eq("conf0_grant", 64'(obs_ready), 64'(4'b0101));
        bus.req_valid = 4'b0010;
        cycle("conf1"); check_eq("conf1_grant", 64'(obs_ready), 64'(4'b0010));
        bus.req_valid = '0;
        cycle("idle0");
        cycle("idle1"); check_eq("idle1_wb_en", 64'(obs_wb_en), 64'(0));

        apply_reset();
        bus.req_valid = 4'b1101;
        bus.req_index[0] = PW'(7);
        bus.req_index[2] = PW'(7);
        bus.req_index[3] = PW'(4);
        cycle("stv0");
        cycle("stv1"); check_eq("stv1_grant", 64'(obs_ready), 64'(4'b1001));
        cycle("stv2");
        check_eq("stv2_starved", 64'(obs_starved), 64'(4'b0100));
        check_eq("stv2_grant", 64'(obs_ready), 64'(4'b1100));
        bus.req_valid[2] = 1'b0;
        cycle("stv3"); check_eq("stv3_starved", 64'(obs_starved), 64'(0));
        bus.req_valid = '0;
        cycle("stv4");

        apply_reset();
        bus.req_valid    = 4'b1000;
        bus.req_index[3] = PW'(127);
        bus.req_data[3]  = 64'hDEAD_BEEF_0000_0001;
        cycle("lat0");
        bus.req_valid = '0;
        cycle("lat1");
        check_eq("lat1_wb_en", 64'(obs_wb_en), 64'(2'b01));
        check_eq("lat1_index", 64'(obs_idx0), 64'(127));
        check_eq("lat1_data", obs_data0, 64'hDEAD_BEEF_0000_0001);

        bus.req_valid = '1;
        for (int i = 0; i < NR; i++) bus.req_index[i] = PW'(20 + i);
        cycle("as0");
        cycle("as1");
        check_eq("as_pre_wb_en", 64'(bus.wb_en), 64'(2'b11));
        #2 rst = 1'b1;
        #1;
        check_eq("as_wb_en", 64'(bus.wb_en), 64'(0));
        check_eq("as_ready", 64'(bus.req_ready), 64'(0));
        check_eq("as_starved", 64'(bus.starved), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle("as2"); check_eq("as2_grant", 64'(obs_ready), 64'(4'b0011));

        apply_reset();
        for (int i = 0; i < NR; i++) new_req(i);
        for (int n = 0; n < 80; n++) begin
            cycle("rnd");
            for (int i = 0; i < NR; i++)
                if (m_rdy[i] || !bus.req_valid[i]) new_req(i);
        end
        bus.req_valid = '0;
        cycle("drain0");
        cycle("drain1");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
